// File: rtl/hiscore_ram_arbiter.sv
// Shares one game work-RAM port between the CPU and the hiscore engine: pauses
// the CPU, waits for the bus to settle, then hands the port to the hiscore side.
module hiscore_ram_arbiter #(
    parameter int unsigned AW             = 10,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned RELEASE_CYCLES = 2,
    parameter int unsigned ACK_TIMEOUT    = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          hs_access,
    input  logic [AW-1:0] hs_address,
    input  logic [7:0]    hs_wdata,
    input  logic          hs_write,
    output logic [7:0]    hs_rdata,
    output logic          hs_granted,
    output logic          hs_write_drop,
    input  logic [AW-1:0] cpu_address,
    input  logic [7:0]    cpu_wdata,
    input  logic          cpu_write,
    input  logic          cpu_paused,
    output logic          pause_cpu,
    output logic [AW-1:0] ram_address,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    input  logic [7:0]    ram_q
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        SETTLE,
        GRANTED,
        RELEASE
    } state_t;

    localparam logic [7:0]  SETTLE_LOAD  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  RELEASE_LOAD = 8'(RELEASE_CYCLES);
    localparam logic [31:0] TIMEOUT_LAST = 32'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  phase_cnt;
    logic [31:0] wait_cnt;
    logic        grant_d1;
    logic        own_port;

    assign own_port = (state == GRANTED);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            pause_cpu  <= 1'b0;
            hs_granted <= 1'b0;
            phase_cnt  <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs_access) begin
                        state     <= WAIT_ACK;
                        pause_cpu <= 1'b1;
                        wait_cnt  <= '0;
                    end
                end
                WAIT_ACK: begin
                    if (!hs_access) begin
                        state     <= RELEASE;
                        phase_cnt <= RELEASE_LOAD;
                    end else if (cpu_paused ||
                                 (ACK_TIMEOUT != 0 && wait_cnt == TIMEOUT_LAST)) begin
                        state     <= SETTLE;
                        phase_cnt <= SETTLE_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                SETTLE: begin
                    if (!hs_access) begin
                        state     <= RELEASE;
                        phase_cnt <= RELEASE_LOAD;
                    end else if (phase_cnt == 8'd0) begin
                        state      <= GRANTED;
                        hs_granted <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                GRANTED: begin
                    if (!hs_access) begin
                        state      <= RELEASE;
                        phase_cnt  <= RELEASE_LOAD;
                        hs_granted <= 1'b0;
                    end
                end
                RELEASE: begin
                    // Late re-requests are ignored here; they re-arbitrate from IDLE.
                    if (phase_cnt == 8'd0) begin
                        state     <= IDLE;
                        pause_cpu <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pause_cpu  <= 1'b0;
                    hs_granted <= 1'b0;
                end
            endcase
        end
    end

    // grant_d1 marks that ram_q in this cycle answers a hiscore-driven address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_d1      <= 1'b0;
            hs_rdata      <= 8'h00;
            hs_write_drop <= 1'b0;
        end else begin
            grant_d1      <= own_port;
            hs_write_drop <= hs_write && !own_port;
            if (grant_d1) begin
                hs_rdata <= ram_q;
            end
        end
    end

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        ram_address = cpu_address;
        ram_wdata   = cpu_wdata;
        ram_we      = cpu_write;
        if (own_port) begin
            ram_address = hs_address;
            ram_wdata   = hs_wdata;
            ram_we      = hs_write;
        end
    end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Bench for hiscore_ram_arbiter: directed scenarios plus a randomized run
// against a cycle-count reference model and a shadow copy of the RAM.
module tb_hiscore_ram_arbiter;

    localparam int AW      = 10;
    localparam int SETTLE  = 4;
    localparam int REL     = 2;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          hs_access;
    logic [AW-1:0] hs_address;
    logic [7:0]    hs_wdata;
    logic          hs_write;
    logic [7:0]    hs_rdata;
    logic          hs_granted;
    logic          hs_write_drop;
    logic [AW-1:0] cpu_address;
    logic [7:0]    cpu_wdata;
    logic          cpu_write;
    logic          cpu_paused;
    logic          pause_cpu;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_wdata;
    logic          ram_we;
    logic [7:0]    ram_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hiscore_ram_arbiter #(
        .AW(AW), .SETTLE_CYCLES(SETTLE), .RELEASE_CYCLES(REL), .ACK_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .hs_access(hs_access), .hs_address(hs_address), .hs_wdata(hs_wdata),
        .hs_write(hs_write), .hs_rdata(hs_rdata), .hs_granted(hs_granted),
        .hs_write_drop(hs_write_drop),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write),
        .cpu_paused(cpu_paused), .pause_cpu(pause_cpu),
        .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_q(ram_q)
    );

    // Game RAM: synchronous read-first, one cycle latency.
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        ram_q <= mem[ram_address];
        if (ram_we) mem[ram_address] = ram_wdata;
    end

    // Reference model: tracks whether the CPU is held and how many cycles remain
    // in each phase, plus its own shadow of RAM contents.
    logic [7:0] sm [0:(1<<AW)-1];
    bit         m_busy, m_granted, m_drop, m_v1;
    int         m_wait, m_settle_left, m_release_left;
    logic [7:0] m_rdata = 8'h00;
    logic [7:0] m_q1    = 8'h00;

    always @(posedge clk) begin
        bit            own;
        logic [AW-1:0] a;
        own = m_granted;
        a   = own ? hs_address : cpu_address;
        if (!reset_n) begin
            m_rdata = 8'h00;
            m_v1    = 1'b0;
            m_drop  = 1'b0;
        end else begin
            if (m_v1) m_rdata = m_q1;
            m_v1   = own;
            m_drop = hs_write && !own;
        end
        m_q1 = sm[a];
        if (own ? hs_write : cpu_write) sm[a] = own ? hs_wdata : cpu_wdata;

        if (!reset_n) begin
            m_busy = 0; m_granted = 0; m_wait = 0; m_settle_left = 0; m_release_left = 0;
        end else if (m_release_left > 0) begin
            m_release_left--;
            if (m_release_left == 0) m_busy = 0;
        end else if (!m_busy) begin
            if (hs_access) begin
                m_busy = 1;
                m_wait = 0;
            end
        end else if (!hs_access) begin
            m_granted      = 0;
            m_settle_left  = 0;
            m_release_left = REL + 1;
        end else if (m_granted) begin
            // hiscore keeps the port
        end else if (m_settle_left > 0) begin
            m_settle_left--;
            if (m_settle_left == 0) m_granted = 1;
        end else begin
            m_wait++;
            if (cpu_paused || (TIMEOUT > 0 && m_wait == TIMEOUT)) m_settle_left = SETTLE;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [AW-1:0] addr, input logic [7:0] val);
        mem[addr] = val;
        sm[addr]  = val;
    endtask

    task automatic acquire();
        bit got = 0;
        hs_access  = 1'b1;
        cpu_paused = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            next_cycle();
            if (hs_granted === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL acquire: grant not seen within 40 cycles (hs_granted=%b, required 1)", hs_granted);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        hs_access = 1'b1;
        cpu_paused = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_write = 1'($urandom);
            next_cycle();
            n_checks += 4;
            if (pause_cpu !== 1'b0) begin n_fail++; $display("FAIL reset_pause: got %b required 0", pause_cpu); end
            if (hs_granted !== 1'b0) begin n_fail++; $display("FAIL reset_granted: got %b required 0", hs_granted); end
            if (ram_we !== cpu_write) begin n_fail++; $display("FAIL reset_ram_we: got %b required %b", ram_we, cpu_write); end
            if (hs_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h required 00", hs_rdata); end
        end
        hs_access  = 1'b0;
        cpu_write  = 1'b0;
        cpu_paused = 1'b0;
        reset_n    = 1'b1;
        next_cycle();
    endtask

    task automatic test_grant_timing();
        hs_address  = 10'h123;
        cpu_address = 10'h3FF;
        hs_access   = 1'b1;
        next_cycle();
        next_cycle();
        cpu_paused = 1'b1;
        next_cycle();
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            n_checks += 3;
            if (hs_granted !== (k == 4)) begin n_fail++; $display("FAIL grant_timing k=%0d: got %b required %b", k, hs_granted, k == 4); end
            if (pause_cpu !== 1'b1) begin n_fail++; $display("FAIL grant_pause k=%0d: got %b required 1", k, pause_cpu); end
            if (ram_address !== ((k == 4) ? 10'h123 : 10'h3FF)) begin
                n_fail++; $display("FAIL grant_address k=%0d: got %h required %h", k, ram_address, (k == 4) ? 10'h123 : 10'h3FF);
            end
        end
    endtask

    task automatic test_read();
        poke(10'h010, 8'h5A);
        poke(10'h2C3, 8'hC3);
        hs_address  = 10'h010;
        cpu_address = 10'h2C3;
        next_cycle();
        next_cycle();
        n_checks++;
        if (hs_rdata !== 8'h5A) begin n_fail++; $display("FAIL read_latency: got %h required 5a", hs_rdata); end
        hs_access = 1'b0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            n_checks++;
            if (hs_rdata !== 8'h5A) begin n_fail++; $display("FAIL read_hold_cpu i=%0d: got %h required 5a", i, hs_rdata); end
        end
        n_checks++;
        if (pause_cpu !== 1'b0) begin n_fail++; $display("FAIL read_idle_pause: got %b required 0", pause_cpu); end
    endtask

    task automatic test_write_drop();
        bit got = 0;
        hs_access  = 1'b1;
        cpu_paused = 1'b1;
        cpu_write  = 1'b0;
        next_cycle();
        next_cycle();
        hs_write   = 1'b1;
        hs_wdata   = 8'hAA;
        hs_address = 10'h055;
        #1;
        n_checks++;
        if (ram_we !== 1'b0) begin n_fail++; $display("FAIL drop_ram_we: got %b required 0", ram_we); end
        next_cycle();
        hs_write = 1'b0;
        n_checks++;
        if (hs_write_drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b required 1", hs_write_drop); end
        next_cycle();
        n_checks++;
        if (hs_write_drop !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_end: got %b required 0", hs_write_drop); end
        for (int i = 0; i < 10 && !got; i++) begin
            if (hs_granted === 1'b1) got = 1;
            else next_cycle();
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL drop_grant_wait: hs_granted=%b required 1", hs_granted); end
        hs_write = 1'b1;
        #1;
        n_checks += 3;
        if (ram_we !== 1'b1) begin n_fail++; $display("FAIL grant_ram_we: got %b required 1", ram_we); end
        if (ram_wdata !== 8'hAA) begin n_fail++; $display("FAIL grant_ram_wdata: got %h required aa", ram_wdata); end
        if (ram_address !== 10'h055) begin n_fail++; $display("FAIL grant_ram_address: got %h required 055", ram_address); end
        next_cycle();
        hs_write = 1'b0;
        n_checks++;
        if (hs_write_drop !== 1'b0) begin n_fail++; $display("FAIL grant_no_drop: got %b required 0", hs_write_drop); end
        next_cycle();
        next_cycle();
        n_checks++;
        if (hs_rdata !== 8'hAA) begin n_fail++; $display("FAIL write_readback: got %h required aa", hs_rdata); end
    endtask

    task automatic test_release();
        hs_access   = 1'b0;
        hs_write    = 1'b1;
        hs_wdata    = 8'h3C;
        hs_address  = 10'h077;
        cpu_address = 10'h100;
        cpu_write   = 1'b0;
        #1;
        n_checks += 2;
        if (ram_we !== 1'b1) begin n_fail++; $display("FAIL release_last_write: got %b required 1", ram_we); end
        if (ram_address !== 10'h077) begin n_fail++; $display("FAIL release_last_addr: got %h required 077", ram_address); end
        next_cycle();
        hs_write = 1'b0;
        #1;
        n_checks += 2;
        if (ram_address !== 10'h100) begin n_fail++; $display("FAIL release_cpu_addr: got %h required 100", ram_address); end
        if (hs_granted !== 1'b0) begin n_fail++; $display("FAIL release_granted: got %b required 0", hs_granted); end
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) next_cycle();
            n_checks++;
            if (pause_cpu !== 1'b1) begin n_fail++; $display("FAIL release_pause k=%0d: got %b required 1", k, pause_cpu); end
        end
        next_cycle();
        n_checks++;
        if (pause_cpu !== 1'b0) begin n_fail++; $display("FAIL release_idle: got %b required 0", pause_cpu); end
    endtask

    task automatic test_back_to_back();
        logic exp_pause [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        acquire();
        hs_access = 1'b0;
        next_cycle();
        hs_access = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            n_checks += 2;
            if (pause_cpu !== exp_pause[k]) begin n_fail++; $display("FAIL b2b_pause k=%0d: got %b required %b", k, pause_cpu, exp_pause[k]); end
            if (hs_granted !== 1'b0) begin n_fail++; $display("FAIL b2b_granted k=%0d: got %b required 0", k, hs_granted); end
        end
        acquire();
        hs_address = 10'h077;
        next_cycle();
        next_cycle();
        n_checks++;
        if (hs_rdata !== 8'h3C) begin n_fail++; $display("FAIL b2b_readback: got %h required 3c", hs_rdata); end
        hs_access = 1'b0;
        repeat (5) next_cycle();
    endtask

    task automatic test_timeout();
        cpu_paused = 1'b0;
        hs_access  = 1'b1;
        next_cycle();
        for (int k = 1; k <= TIMEOUT + SETTLE; k++) begin
            next_cycle();
            n_checks++;
            if (hs_granted !== (k == TIMEOUT + SETTLE)) begin
                n_fail++; $display("FAIL timeout_grant k=%0d: got %b required %b", k, hs_granted, k == TIMEOUT + SETTLE);
            end
        end
        reset_n = 1'b0;
        next_cycle();
        n_checks += 3;
        if (pause_cpu !== 1'b0) begin n_fail++; $display("FAIL midreset_pause: got %b required 0", pause_cpu); end
        if (hs_granted !== 1'b0) begin n_fail++; $display("FAIL midreset_granted: got %b required 0", hs_granted); end
        if (ram_address !== cpu_address) begin n_fail++; $display("FAIL midreset_addr: got %h required %h", ram_address, cpu_address); end
        reset_n   = 1'b1;
        hs_access = 1'b0;
        next_cycle();
    endtask

    task automatic test_random();
        bit ack_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0) hs_access = ~hs_access;
            if ($urandom_range(0, 49) == 0) ack_mode = ~ack_mode;
            cpu_paused  = ack_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
            reset_n     = ($urandom_range(0, 299) != 0);
            hs_write    = ($urandom_range(0, 3) == 0);
            hs_wdata    = 8'($urandom);
            hs_address  = AW'($urandom_range(0, 15));
            cpu_write   = ($urandom_range(0, 3) == 0);
            cpu_wdata   = 8'($urandom);
            cpu_address = AW'($urandom_range(0, 15));
            @(negedge clk);
            n_checks += 7;
            if (pause_cpu !== m_busy) begin n_fail++; $display("FAIL rnd_pause c=%0d: got %b required %b", c, pause_cpu, m_busy); end
            if (hs_granted !== m_granted) begin n_fail++; $display("FAIL rnd_granted c=%0d: got %b required %b", c, hs_granted, m_granted); end
            if (ram_address !== (m_granted ? hs_address : cpu_address)) begin
                n_fail++; $display("FAIL rnd_addr c=%0d: got %h required %h", c, ram_address, m_granted ? hs_address : cpu_address);
            end
            if (ram_we !== (m_granted ? hs_write : cpu_write)) begin
                n_fail++; $display("FAIL rnd_we c=%0d: got %b required %b", c, ram_we, m_granted ? hs_write : cpu_write);
            end
            if (ram_wdata !== (m_granted ? hs_wdata : cpu_wdata)) begin
                n_fail++; $display("FAIL rnd_wdata c=%0d: got %h required %h", c, ram_wdata, m_granted ? hs_wdata : cpu_wdata);
            end
            if (hs_rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata c=%0d: got %h required %h", c, hs_rdata, m_rdata); end
            if (hs_write_drop !== m_drop) begin n_fail++; $display("FAIL rnd_drop c=%0d: got %b required %b", c, hs_write_drop, m_drop); end
            next_cycle();
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        hs_access   = 1'b0;
        hs_address  = '0;
        hs_wdata    = 8'h00;
        hs_write    = 1'b0;
        cpu_address = '0;
        cpu_wdata   = 8'h00;
        cpu_write   = 1'b0;
        cpu_paused  = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin
            logic [7:0] v;
            v     = 8'($urandom);
            mem[i] = v;
            sm[i]  = v;
        end
        next_cycle();
        test_reset();
        test_grant_timing();
        test_read();
        test_write_drop();
        test_release();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
